// File: rtl/stage3_q_merge_pkg.sv
// stage3_q_merge_pkg: shared widths, lane encoding and round-robin helper for the stage-3 merge.
// Provides no ports; imported by stage3_q_merge and stage3_msg_fifo.
package stage3_q_merge_pkg;
  localparam int MAX_MESSAGE_BITS = 64;
  localparam int STAGE3_FIFO_DEPTH = 4;
  localparam int STAGE3_LANES = 3;
  localparam int STAGE3_CNT_W = 32;
  typedef enum logic [1:0] {LANE_1 = 2'd0, LANE_2 = 2'd1, LANE_3 = 2'd2} lane_e;
  function automatic lane_e next_lane(lane_e l);
    return l == LANE_3 ? LANE_1 : lane_e'(l + 2'd1);
  endfunction
endpackage

// File: rtl/stage3_msg_fifo.sv
// stage3_msg_fifo: show-ahead synchronous FIFO holding one lane's formatted messages.
// Ports: clk, rst_n (async active-low), push/din write, pop advances head, dout = head,
//        full/empty from the registered occupancy count.
module stage3_msg_fifo #(
  parameter int MSG_W = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [MSG_W-1:0] din,
  output logic [MSG_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [MSG_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/stage3_q_merge.sv
// stage3_q_merge: buffers three stage-2 quote lanes and merges them round-robin onto one registered bus.
// Ports: message_q_1..3/valid_q/ready_q lane inputs, message_out/lane_out/valid_out/ready_out
//        output handshake, msg_count delivered messages, overflow_seen sticky per-lane drop flags.
module stage3_q_merge
  import stage3_q_merge_pkg::*;
#(
  parameter int MSG_W = MAX_MESSAGE_BITS,
  parameter int FIFO_DEPTH = STAGE3_FIFO_DEPTH,
  parameter int CNT_W = STAGE3_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MSG_W-1:0] message_q_1,
  input  logic [MSG_W-1:0] message_q_2,
  input  logic [MSG_W-1:0] message_q_3,
  input  logic [2:0]       valid_q,
  output logic [2:0]       ready_q,
  output logic [MSG_W-1:0] message_out,
  output logic [1:0]       lane_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [CNT_W-1:0] msg_count,
  output logic [2:0]       overflow_seen
);
  logic [MSG_W-1:0] din [3];
  logic [MSG_W-1:0] head [3];
  logic [2:0] full, empty, push, pop, ne;
  lane_e rr, c1, c2, sel;
  logic load, any;
  assign din = '{message_q_1, message_q_2, message_q_3};
  for (genvar g = 0; g < STAGE3_LANES; g++) begin : g_lane
    stage3_msg_fifo #(.MSG_W(MSG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push[g]), .pop(pop[g]),
      .din(din[g]), .dout(head[g]), .full(full[g]), .empty(empty[g])
    );
  end
  assign ready_q = ~full;
  assign push = valid_q & ready_q;
  assign ne = ~empty;
  assign any = |ne;
  assign load = !valid_out || ready_out;
  // Scan order rr, rr+1, rr+2; c2 is taken when neither earlier lane has data (or nothing does).
  always_comb begin
    c1 = next_lane(rr);
    c2 = next_lane(c1);
    sel = ne[rr] ? rr : ne[c1] ? c1 : c2;
    pop = (load && any) ? 3'b001 << sel : 3'b000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      message_out <= '0;
      lane_out <= '0;
      valid_out <= 1'b0;
      rr <= LANE_1;
      msg_count <= '0;
      overflow_seen <= '0;
    end else begin
      overflow_seen <= overflow_seen | (valid_q & ~ready_q);
      if (valid_out && ready_out) msg_count <= msg_count + CNT_W'(1);
      if (load) begin
        valid_out <= any;
        if (any) begin
          message_out <= head[sel];
          lane_out <= 2'(sel) + 2'd1;
          rr <= next_lane(sel);
        end
      end
    end
  end
endmodule

// File: tb/tb_stage3_q_merge.sv
// tb_stage3_q_merge: directed scoreboard bench for stage3_q_merge (default build plus a CNT_W=4 build).
module tb_stage3_q_merge;
  import stage3_q_merge_pkg::*;
  localparam int W = MAX_MESSAGE_BITS;
  typedef struct packed {logic [1:0] lane; logic [W-1:0] msg;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ready_out = 1'b0;
  logic [W-1:0] message_q_1 = '0, message_q_2 = '0, message_q_3 = '0;
  logic [2:0] valid_q = '0;
  logic [2:0] ready_q, overflow_seen, ready_q4, overflow_seen4;
  logic [W-1:0] message_out, message_out4;
  logic [1:0] lane_out, lane_out4;
  logic valid_out, valid_out4;
  logic [31:0] msg_count;
  logic [3:0] msg_count4;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, hs = 0;
  always #5 clk = ~clk;
  stage3_q_merge dut (
    .clk(clk), .rst_n(rst_n), .message_q_1(message_q_1), .message_q_2(message_q_2),
    .message_q_3(message_q_3), .valid_q(valid_q), .ready_q(ready_q), .message_out(message_out),
    .lane_out(lane_out), .valid_out(valid_out), .ready_out(ready_out), .msg_count(msg_count),
    .overflow_seen(overflow_seen)
  );
  stage3_q_merge #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .message_q_1(message_q_1), .message_q_2(message_q_2),
    .message_q_3(message_q_3), .valid_q(valid_q), .ready_q(ready_q4), .message_out(message_out4),
    .lane_out(lane_out4), .valid_out(valid_out4), .ready_out(ready_out), .msg_count(msg_count4),
    .overflow_seen(overflow_seen4)
  );
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string n);
    int c = 0;
    while (q.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d_left expected=0_left", n, q.size());
      q.delete();
    end
    step();
  endtask
  task automatic check_reset(input string n);
    check({n, "_valid"}, valid_out, 0);
    check({n, "_msg"}, message_out, 0);
    check({n, "_lane"}, lane_out, 0);
    check({n, "_ready"}, ready_q, 3'b111);
    check({n, "_count"}, msg_count, 0);
    check({n, "_ovf"}, overflow_seen, 0);
    check({n, "_count4"}, msg_count4, 0);
  endtask
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=lane%0d:%0h expected=none", lane_out, message_out);
      end else begin
        e = q.pop_front();
        check("out_lane", lane_out, e.lane);
        check("out_msg", message_out, e.msg);
      end
      hs++;
    end
  end
  initial begin
    #2;
    check_reset("rst_init");
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    check_reset("idle");
    ready_out = 1'b1;
    q.push_back('{2'd2, W'('hA5)});
    message_q_2 = W'('hA5);
    valid_q = 3'b010;
    step();
    valid_q = 3'b000;
    step();
    check("single_valid", valid_out, 1);
    check("single_lane", lane_out, 2);
    check("single_msg", message_out, 'hA5);
    step();
    check("single_count", msg_count, 1);
    check("single_done", valid_out, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    hs = 0;
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) q.push_back('{2'(i), W'(i)});
    message_q_1 = W'(1);
    message_q_2 = W'(2);
    message_q_3 = W'(3);
    valid_q = 3'b111;
    step();
    valid_q = 3'b000;
    drain("three");
    check("three_count", msg_count, 3);
    check("three_idle", valid_out, 0);
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      message_q_1 = W'('h50 + i);
      q.push_back('{2'd1, W'('h50 + i)});
      valid_q = 3'b001;
      step();
    end
    check("bp_ready", ready_q, 3'b110);
    check("bp_ovf_pre", overflow_seen, 0);
    check("bp_valid", valid_out, 1);
    check("bp_lane", lane_out, 1);
    check("bp_msg", message_out, 'h50);
    message_q_1 = W'('h55);
    step();
    valid_q = 3'b000;
    check("bp_ovf", overflow_seen, 3'b001);
    check("bp_ready_hold", ready_q, 3'b110);
    check("bp_msg_hold", message_out, 'h50);
    ready_out = 1'b1;
    drain("bp");
    check("bp_count", msg_count, 8);
    ready_out = 1'b0;
    message_q_1 = W'('h70);
    message_q_2 = W'('h71);
    message_q_3 = W'('h72);
    valid_q = 3'b111;
    step();
    step();
    check("burst_valid", valid_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    hs = 0;
    valid_q = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    step();
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{2'd1, W'('h10 + i)});
      q.push_back('{2'd3, W'('h30 + i)});
    end
    for (int i = 0; i < 4; i++) begin
      message_q_1 = W'('h10 + i);
      message_q_3 = W'('h30 + i);
      valid_q = 3'b101;
      step();
    end
    valid_q = 3'b000;
    drain("fair");
    check("fair_count", msg_count, 8);
    for (int i = 0; i < 9; i++) begin
      message_q_2 = W'('hB0 + i);
      q.push_back('{2'd2, W'('hB0 + i)});
      valid_q = 3'b010;
      step();
    end
    valid_q = 3'b000;
    drain("wrap");
    check("wrap_count32", msg_count, 17);
    check("wrap_model", msg_count, hs);
    check("wrap_count4", msg_count4, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
